btn_event_gen: RTL and testbench

- Sits directly downstream of the debouncer; consumes its clean, synchronous button level (`btn_state`).
- Converts that level into single-cycle event pulses: press, release, long-press, and auto-repeat while held.
- Feeds the game/control FSMs, which act on events rather than levels.
- One instance per button.

---
 rtl/btn_pkg.sv | 27 ++
 rtl/btn_event_gen_if.sv | 45 ++++
 rtl/btn_edge_detect.sv | 44 ++++
 rtl/btn_event_gen.sv | 134 +++++++++++++
 tb/tb_btn_event_gen.sv | 125 ++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared types and default timing constants for the button
//                event generator (100 MHz system clock defaults).
//  Contents    : btn_state_t   - event FSM state encoding
//                LONG_CYCLES_DEF, REPEAT_CYCLES_DEF, CNT_W_DEF
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_pkg;

    // Explicit 2-bit encoding keeps the state register width fixed.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } btn_state_t;

    // 1 s to long-press, 200 ms repeat period at 100 MHz.
    localparam int LONG_CYCLES_DEF   = 100_000_000;
    localparam int REPEAT_CYCLES_DEF = 20_000_000;
    localparam int CNT_W_DEF         = 27;

endpackage : btn_pkg

`default_nettype wire

// File: rtl/btn_event_gen_if.sv
// ============================================================================
//  Module      : btn_event_gen_if
//  Description : Level-in / events-out bundle of one button channel.
//  Signals     : btn_state   - debounced, clk-synchronous button level
//                press       - 1-cycle pulse on 0->1 of btn_state
//                release_evt - 1-cycle pulse on 1->0 of btn_state
//                long_press  - 1-cycle pulse after LONG_CYCLES of hold
//                repeat_evt  - 1-cycle pulse every REPEAT_CYCLES past long
//                held        - level, high while the button is held
//  Modports    : master - drives the level, observes events
//                slave  - the event generator
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface btn_event_gen_if;

    logic btn_state;
    logic press;
    logic release_evt;   // "release" is a reserved word in SystemVerilog
    logic long_press;
    logic repeat_evt;    // "repeat" is a reserved word in SystemVerilog
    logic held;

    modport master (
        output btn_state,
        input  press,
        input  release_evt,
        input  long_press,
        input  repeat_evt,
        input  held
    );

    modport slave (
        input  btn_state,
        output press,
        output release_evt,
        output long_press,
        output repeat_evt,
        output held
    );

endinterface : btn_event_gen_if

`default_nettype wire

// File: rtl/btn_edge_detect.sv
// ============================================================================
//  Module      : btn_edge_detect
//  Description : Registers the previous sample of a synchronous level and
//                flags rising / falling transitions against it.
//  Ports       : clk     - system clock
//                rst     - synchronous active-high reset (clears history)
//                i_level - synchronous level input
//                o_rise  - combinational, high when level=1 and prev=0
//                o_fall  - combinational, high when level=0 and prev=1
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_edge_detect (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_level,
    output logic      o_rise,
    output logic      o_fall
);

    logic r_prev_q;
    logic w_prev_d;

    always_comb begin
        w_prev_d = i_level;
    end

    // History resets to 0, so a level already high when reset drops is
    // reported as a fresh rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_q <= 1'b0;
        end else begin
            r_prev_q <= w_prev_d;
        end
    end

    assign o_rise =  i_level & ~r_prev_q;
    assign o_fall = ~i_level &  r_prev_q;

endmodule : btn_edge_detect

`default_nettype wire

// File: rtl/btn_event_gen.sv
// ============================================================================
//  Module      : btn_event_gen
//  Description : Converts a debounced button level into single-cycle events:
//                press, release, long-press and auto-repeat while held.
//  Parameters  : LONG_CYCLES   - cycles from press to long_press (>= 2)
//                REPEAT_CYCLES - cycles between long_press/repeats (>= 2)
//                CNT_W         - hold counter width, 2^CNT_W > max(above)
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                bus  - btn_event_gen_if.slave (level in, events out)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_event_gen
    import btn_pkg::*;
#(
    parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  wire logic       clk,
    input  wire logic       rst,
    btn_event_gen_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic w_rise;
    logic w_fall;

    btn_edge_detect u_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (bus.btn_state),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    btn_state_t       r_state_q,   w_state_d;
    logic [CNT_W-1:0] r_cnt_q,     w_cnt_d;
    logic             r_press_q,   w_press_d;
    logic             r_release_q, w_release_d;
    logic             r_long_q,    w_long_d;
    logic             r_repeat_q,  w_repeat_d;
    logic             r_held_q,    w_held_d;

    // Pulses default low every cycle so each one lasts exactly one clock.
    // In the held states a falling edge is checked before the threshold so
    // release wins a same-cycle collision with long_press/repeat.
    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_press_d   = 1'b0;
        w_release_d = 1'b0;
        w_long_d    = 1'b0;
        w_repeat_d  = 1'b0;
        w_held_d    = r_held_q;

        case (r_state_q)
            IDLE: begin
                if (w_rise) begin
                    w_state_d = PRESSED;
                    w_press_d = 1'b1;
                    w_cnt_d   = '0;
                    w_held_d  = 1'b1;
                end
            end
            PRESSED: begin
                if (w_fall) begin
                    w_state_d   = IDLE;
                    w_release_d = 1'b1;
                    w_cnt_d     = '0;
                    w_held_d    = 1'b0;
                end else if (r_cnt_q == c_LONG_LAST) begin
                    w_state_d = LONG_HELD;
                    w_long_d  = 1'b1;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                end
            end
            LONG_HELD: begin
                if (w_fall) begin
                    w_state_d   = IDLE;
                    w_release_d = 1'b1;
                    w_cnt_d     = '0;
                    w_held_d    = 1'b0;
                end else if (r_cnt_q == c_REPEAT_LAST) begin
                    w_repeat_d = 1'b1;
                    w_cnt_d    = '0;
                end else begin
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                w_state_d = IDLE;
                w_cnt_d   = '0;
                w_held_d  = 1'b0;
            end
        endcase
    end

    // Reset silently abandons any hold: no release pulse is produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= IDLE;
            r_cnt_q     <= '0;
            r_press_q   <= 1'b0;
            r_release_q <= 1'b0;
            r_long_q    <= 1'b0;
            r_repeat_q  <= 1'b0;
            r_held_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_press_q   <= w_press_d;
            r_release_q <= w_release_d;
            r_long_q    <= w_long_d;
            r_repeat_q  <= w_repeat_d;
            r_held_q    <= w_held_d;
        end
    end

    assign bus.press       = r_press_q;
    assign bus.release_evt = r_release_q;
    assign bus.long_press  = r_long_q;
    assign bus.repeat_evt  = r_repeat_q;
    assign bus.held        = r_held_q;

endmodule : btn_event_gen

`default_nettype wire

// File: tb/tb_btn_event_gen.sv
// ============================================================================
//  Module      : tb_btn_event_gen
//  Description : Directed self-checking bench for btn_event_gen with
//                LONG_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4. Each step drives
//                btn_state/rst, lets one rising edge pass and compares the
//                output vector {press,release,long,repeat,held} visible in
//                the following cycle with a hand-derived value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_event_gen;

    logic clk;
    logic rst;

    btn_event_gen_if u_if ();

    btn_event_gen #(
        .LONG_CYCLES   (8),
        .REPEAT_CYCLES (4),
        .CNT_W         (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector bit masks: {press, release, long_press, repeat, held}
    localparam logic [4:0] c_Z = 5'b00000;
    localparam logic [4:0] c_P = 5'b10000;
    localparam logic [4:0] c_R = 5'b01000;
    localparam logic [4:0] c_L = 5'b00100;
    localparam logic [4:0] c_T = 5'b00010;
    localparam logic [4:0] c_H = 5'b00001;

    int n_vec;
    int n_err;

    task automatic step(input logic b, input logic r, input logic [4:0] exp_v, input string tag);
        logic [4:0] obs;
        u_if.btn_state = b;
        rst            = r;
        @(posedge clk);
        #1;
        obs = {u_if.press, u_if.release_evt, u_if.long_press, u_if.repeat_evt, u_if.held};
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b (press,rel,long,rpt,held)", tag, obs, exp_v);
        end
    endtask

    initial begin
        logic [4:0] e;
        n_vec = 0;
        n_err = 0;
        u_if.btn_state = 1'b0;
        rst            = 1'b1;

        // Reset values, with btn_state held high during reset
        step(1'b0, 1'b1, c_Z, "reset_idle");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, c_Z, "reset_btn_high");
        step(1'b1, 1'b0, c_P | c_H, "press_after_reset");
        step(1'b1, 1'b0, c_H,       "held_after_reset");
        step(1'b0, 1'b0, c_R,       "release_after_reset");
        step(1'b0, 1'b0, c_Z,       "idle_after_reset");
        step(1'b0, 1'b0, c_Z,       "idle_gap0");

        // Short tap: three high samples
        step(1'b1, 1'b0, c_P | c_H, "tap_press");
        step(1'b1, 1'b0, c_H,       "tap_held1");
        step(1'b1, 1'b0, c_H,       "tap_held2");
        step(1'b0, 1'b0, c_R,       "tap_release");
        step(1'b0, 1'b0, c_Z,       "tap_idle");

        // Long hold: 31 high samples -> long at step 9, repeats 13,17,...,29
        for (int k = 1; k <= 31; k++) begin
            e = c_H;
            if (k == 1) e = e | c_P;
            if (k == 9) e = e | c_L;
            if (k >= 13 && ((k - 13) % 4) == 0) e = e | c_T;
            step(1'b1, 1'b0, e, $sformatf("hold_k%0d", k));
        end
        step(1'b0, 1'b0, c_R, "hold_release");
        step(1'b0, 1'b0, c_Z, "hold_idle");

        // Release coincides with the long-press threshold
        step(1'b1, 1'b0, c_P | c_H, "coll_press");
        for (int k = 2; k <= 8; k++) step(1'b1, 1'b0, c_H, $sformatf("coll_k%0d", k));
        step(1'b0, 1'b0, c_R, "coll_release_no_long");
        step(1'b0, 1'b0, c_Z, "coll_idle");

        // Reset in the middle of a long hold, button kept down
        for (int k = 1; k <= 11; k++) begin
            e = c_H;
            if (k == 1) e = e | c_P;
            if (k == 9) e = e | c_L;
            step(1'b1, 1'b0, e, $sformatf("mid_k%0d", k));
        end
        step(1'b1, 1'b1, c_Z, "mid_rst1_no_release");
        step(1'b1, 1'b1, c_Z, "mid_rst2");
        step(1'b1, 1'b0, c_P | c_H, "mid_repress");
        for (int k = 2; k <= 8; k++) step(1'b1, 1'b0, c_H, $sformatf("mid_re_k%0d", k));
        step(1'b1, 1'b0, c_L | c_H, "mid_long_again");
        step(1'b0, 1'b0, c_R,       "mid_release");
        step(1'b0, 1'b0, c_Z,       "mid_idle");

        // Rapid toggles: press/release alternate, never overlap
        for (int k = 0; k < 10; k++) begin
            if ((k % 2) == 0) step(1'b1, 1'b0, c_P | c_H, $sformatf("tog_press%0d", k));
            else              step(1'b0, 1'b0, c_R,       $sformatf("tog_release%0d", k));
        end
        step(1'b0, 1'b0, c_Z, "tog_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_btn_event_gen

`default_nettype wire
